// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared types, constants and helpers for the gate pattern driver
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_AND    = 0;
    localparam int OP_OR     = 1;
    localparam int MAX_PORTS = 8;

    // Value that leaves the gate result unchanged: all-ones for AND, zero for OR.
    function automatic logic [31:0] identity(input int op, input int width);
        return (op == OP_AND) ? (32'hFFFF_FFFF >> (32 - width)) : 32'h0;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational expected result of the gate for one vector
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int PORT_NUM = 8,
    parameter int WIDTH    = 8,
    parameter int OP       = OP_AND
) (
    input  logic [MAX_PORTS-1:0] vec,
    output logic [WIDTH-1:0]     expected
);

    logic [PORT_NUM-1:0] active;

    assign active   = vec[PORT_NUM-1:0];
    assign expected = (OP == OP_OR) ? {WIDTH{|active}} : {WIDTH{&active}};

endmodule

// File: rtl/gate_pattern_driver.sv
// rtl/gate_pattern_driver.sv - exhaustive operand sweep and result checker for an 8-input gate
module gate_pattern_driver
    import gate_pkg::*;
#(
    parameter int PORT_NUM = 8,
    parameter int WIDTH    = 8,
    parameter int OP       = 0,
    parameter int DUT_LAT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [8:0]       err_cnt,
    output logic [7:0]       first_fail,
    output logic             first_fail_vld
);

    localparam logic [WIDTH-1:0] IDENT    = WIDTH'(identity(OP, WIDTH));
    localparam logic [8:0]       LAST_VEC = 9'((1 << PORT_NUM) - 1);
    localparam logic [1:0]       LAT_MAX  = 2'(DUT_LAT);

    state_t           state;
    logic [8:0]       vec_cnt;
    logic [1:0]       lat_cnt;
    logic [WIDTH-1:0] opnd [MAX_PORTS];
    logic [WIDTH-1:0] expected;
    logic             mismatch;
    logic [8:0]       err_inc;

    // Operand i of vector v: its bit replicated on active ports, identity elsewhere.
    function automatic logic [WIDTH-1:0] operand_for(input logic [8:0] v, input int i);
        if (i < PORT_NUM) begin
            return {WIDTH{v[i]}};
        end
        return IDENT;
    endfunction

    gate_ref_model #(
        .PORT_NUM (PORT_NUM),
        .WIDTH    (WIDTH),
        .OP       (OP)
    ) u_ref (
        .vec      (vec_cnt[MAX_PORTS-1:0]),
        .expected (expected)
    );

    // The error counter stops at 256, which a 256-vector sweep can reach but never pass.
    assign mismatch = (q != expected);
    assign err_inc  = (mismatch && (err_cnt != 9'd256)) ? err_cnt + 9'd1 : err_cnt;

    assign a = opnd[0];
    assign b = opnd[1];
    assign c = opnd[2];
    assign d = opnd[3];
    assign e = opnd[4];
    assign f = opnd[5];
    assign g = opnd[6];
    assign h = opnd[7];

    // Sweep FSM: drives each vector for DUT_LAT+1 cycles and checks q on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec_cnt        <= '0;
            lat_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            for (int i = 0; i < MAX_PORTS; i++) begin
                opnd[i] <= IDENT;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (start) begin
                        state          <= RUN;
                        vec_cnt        <= '0;
                        lat_cnt        <= '0;
                        err_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        for (int i = 0; i < MAX_PORTS; i++) begin
                            opnd[i] <= operand_for(9'd0, i);
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        for (int i = 0; i < MAX_PORTS; i++) begin
                            opnd[i] <= IDENT;
                        end
                    end else if (lat_cnt == LAT_MAX) begin
                        err_cnt <= err_inc;
                        if (mismatch && !first_fail_vld) begin
                            first_fail     <= vec_cnt[7:0];
                            first_fail_vld <= 1'b1;
                        end
                        if (vec_cnt == LAST_VEC) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_inc == 9'd0);
                            for (int i = 0; i < MAX_PORTS; i++) begin
                                opnd[i] <= IDENT;
                            end
                        end else begin
                            vec_cnt <= vec_cnt + 9'd1;
                            lat_cnt <= '0;
                            for (int i = 0; i < MAX_PORTS; i++) begin
                                opnd[i] <= operand_for(vec_cnt + 9'd1, i);
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pattern_driver.sv
// tb/tb_gate_pattern_driver.sv - scoreboard bench for gate_pattern_driver with three gate configurations
module tb_gate_pattern_driver;

    typedef struct {
        string tag;
        int    cycles;
        int    err;
        int    ff;
        int    ffv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_s;
    logic [2:0] abort_s;
    logic       stuck0;

    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [2:0] ffv_v;
    logic [8:0] err_v [3];
    logic [7:0] ff_v  [3];

    logic [7:0] ops0;
    logic [7:0] ops1 [8];
    logic [7:0] ops2 [8];
    logic       q0;
    logic [7:0] q1_s1;
    logic [7:0] q1;
    logic [7:0] q2;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_vec  = 0;

    always #5 clk = ~clk;

    // Gate 0: 8-input, 1-bit AND, optionally stuck at 0.
    assign q0 = (&ops0) & ~stuck0;

    // Gate 1: 8-bit AND with two register stages.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_s1 <= 8'h00;
            q1    <= 8'h00;
        end else begin
            q1_s1 <= ops1[0] & ops1[1] & ops1[2] & ops1[3] & ops1[4] & ops1[5] & ops1[6] & ops1[7];
            q1    <= q1_s1;
        end
    end

    // Gate 2: 8-bit OR with bit 0 stuck at 1.
    assign q2 = ops2[0] | ops2[1] | ops2[2] | ops2[3] | ops2[4] | ops2[5] | ops2[6] | ops2[7] | 8'h01;

    gate_pattern_driver #(.PORT_NUM(8), .WIDTH(1), .OP(0), .DUT_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]), .q(q0),
        .a(ops0[0]), .b(ops0[1]), .c(ops0[2]), .d(ops0[3]),
        .e(ops0[4]), .f(ops0[5]), .g(ops0[6]), .h(ops0[7]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
        .first_fail(ff_v[0]), .first_fail_vld(ffv_v[0])
    );

    gate_pattern_driver #(.PORT_NUM(2), .WIDTH(8), .OP(0), .DUT_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]), .q(q1),
        .a(ops1[0]), .b(ops1[1]), .c(ops1[2]), .d(ops1[3]),
        .e(ops1[4]), .f(ops1[5]), .g(ops1[6]), .h(ops1[7]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
        .first_fail(ff_v[1]), .first_fail_vld(ffv_v[1])
    );

    gate_pattern_driver #(.PORT_NUM(3), .WIDTH(8), .OP(1), .DUT_LAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]), .q(q2),
        .a(ops2[0]), .b(ops2[1]), .c(ops2[2]), .d(ops2[3]),
        .e(ops2[4]), .f(ops2[5]), .g(ops2[6]), .h(ops2[7]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
        .first_fail(ff_v[2]), .first_fail_vld(ffv_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // u0 must present vector k, bit i on operand i, in the k-th busy cycle.
    always @(negedge clk) begin
        if (busy_v[0]) begin
            check("u0_vector", {56'h0, ops0}, {56'h0, mon_vec[7:0]});
            mon_vec++;
        end
    end

    // Unused ports of u1 (AND) sit at all-ones and of u2 (OR) at zero while sweeping.
    always @(negedge clk) begin
        if (busy_v[1]) begin
            check("u1_unused_ports", {16'h0, ops1[2], ops1[3], ops1[4], ops1[5], ops1[6], ops1[7]},
                  {16'h0, 48'hFFFF_FFFF_FFFF});
        end
        if (busy_v[2]) begin
            check("u2_unused_ports", {24'h0, ops2[3], ops2[4], ops2[5], ops2[6], ops2[7]}, 64'h0);
        end
    end

    task automatic do_sweep(input int sel, input string tag, input int exp_err,
                            input int exp_ff, input int exp_ffv);
        exp_t ex;
        int   n;
        int   pn;
        int   lt;
        pn = (sel == 0) ? 8 : (sel == 1) ? 2 : 3;
        lt = (sel == 1) ? 2 : 0;
        ex = '{tag, (1 << pn) * (lt + 1), exp_err, exp_ff, exp_ffv};
        sb.push_back(ex);
        if (sel == 0) mon_vec = 0;
        start_s[sel] = 1'b1;
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy_v[sel]), 64'd1);
        n = 0;
        while (!done_v[sel] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        ex = sb.pop_front();
        check({ex.tag, "_cycles"}, 64'(n), 64'(ex.cycles));
        check({ex.tag, "_err_cnt"}, 64'(err_v[sel]), 64'(ex.err));
        check({ex.tag, "_first_fail_vld"}, 64'(ffv_v[sel]), 64'(ex.ffv));
        if (ex.ffv != 0) check({ex.tag, "_first_fail"}, 64'(ff_v[sel]), 64'(ex.ff));
        check({ex.tag, "_pass"}, 64'(pass_v[sel]), 64'(ex.err == 0));
        check({ex.tag, "_busy_at_done"}, 64'(busy_v[sel]), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = '0;
        abort_s = '0;
        stuck0  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_v), 64'd0);
        check("rst_done", 64'(done_v), 64'd0);
        check("rst_pass", 64'(pass_v), 64'd0);
        check("rst_ffv", 64'(ffv_v), 64'd0);
        check("rst_err0", 64'(err_v[0]), 64'd0);
        check("rst_ff0", 64'(ff_v[0]), 64'd0);
        check("rst_ops0", 64'(ops0), 64'hFF);
        check("rst_ops1_a", 64'(ops1[0]), 64'hFF);
        check("rst_ops2_a", 64'(ops2[0]), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_sweep(0, "and8", 0, 0, 0);
        check("and8_ops_identity", 64'(ops0), 64'hFF);

        stuck0 = 1'b1;
        do_sweep(0, "and8_stuck0", 1, 8'hFF, 1);
        stuck0 = 1'b0;

        do_sweep(1, "and2_lat2", 0, 0, 0);
        check("and2_ops_identity", {48'h0, ops1[0], ops1[1]}, 64'hFFFF);

        do_sweep(2, "or3_bit0", 1, 0, 1);
        check("or3_ops_identity", {40'h0, ops2[0], ops2[1], ops2[2]}, 64'h0);
        check("or3_unused_after", {24'h0, ops2[3], ops2[4], ops2[5], ops2[6], ops2[7]}, 64'h0);

        // Restart ignored during RUN, then abort while vector 10 is driven.
        mon_vec    = 0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("abort_at_vector", 64'(ops0), 64'd10);
        abort_s[0] = 1'b1;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_done", 64'(done_v[0]), 64'd0);
        check("abort_ops_identity", 64'(ops0), 64'hFF);
        check("abort_err_cnt", 64'(err_v[0]), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("abort_stays_idle", 64'(busy_v[0]), 64'd0);
        check("abort_vectors_seen", 64'(mon_vec), 64'd11);

        // Asynchronous reset while vector 100 is driven.
        mon_vec    = 0;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (100) begin @(posedge clk); #1; end
        check("pre_rst_vector", 64'(ops0), 64'd100);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_v), 64'd0);
        check("midrst_done", 64'(done_v), 64'd0);
        check("midrst_pass", 64'(pass_v), 64'd0);
        check("midrst_ffv", 64'(ffv_v), 64'd0);
        check("midrst_err2", 64'(err_v[2]), 64'd0);
        check("midrst_ops0", 64'(ops0), 64'hFF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_sweep(0, "and8_after_rst", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
